// File: rtl/branch_predictor_pkg.sv
// branch_predictor_pkg: shared branch-kind, pcsrc and 2-bit counter constants plus counter helper
package branch_predictor_pkg;
    localparam logic [1:0] BR_NONE     = 2'b00;
    localparam logic [1:0] BR_BTYPE    = 2'b01;
    localparam logic [1:0] BR_JAL      = 2'b10;
    localparam logic [1:0] BR_JALR     = 2'b11;
    localparam logic [1:0] PCSRC_SEQ   = 2'b00;
    localparam logic [1:0] PCSRC_BTYPE = 2'b01;
    localparam logic [1:0] PCSRC_JAL   = 2'b10;
    localparam logic [1:0] PCSRC_JALR  = 2'b11;
    localparam logic [1:0] SNT         = 2'b00;
    localparam logic [1:0] WNT         = 2'b01;
    localparam logic [1:0] WT          = 2'b10;
    localparam logic [1:0] ST          = 2'b11;
    function automatic logic [1:0] cnt_step(input logic [1:0] c, input logic up);
        return up ? (c == ST ? ST : c + 2'd1) : (c == SNT ? SNT : c - 2'd1);
    endfunction
endpackage

// File: rtl/branch_predictor_if.sv
// branch_predictor_if: fetch lookup, execute resolution and prediction signals; perf counters under BRANCH_PREDICTOR_PERF_EN
interface branch_predictor_if #(parameter int WIDTH = 32);
    logic             i_fetch_valid;
    logic [WIDTH-1:0] i_fetch_pc;
    logic             o_pred_valid;
    logic             o_pred_taken;
    logic [WIDTH-1:0] o_pred_target;
    logic             i_ex_valid;
    logic [1:0]       i_branch;
    logic [2:0]       i_funct3;
    logic             i_zero_flag;
    logic [WIDTH-1:0] i_ex_pc;
    logic [WIDTH-1:0] i_ex_target;
    logic             i_ex_pred_taken;
    logic [WIDTH-1:0] i_ex_pred_target;
    logic [1:0]       o_pcsrc;
    logic             o_mispredict;
    logic [WIDTH-1:0] o_redirect_pc;
`ifdef BRANCH_PREDICTOR_PERF_EN
    logic [31:0]      o_branch_cnt;
    logic [31:0]      o_mispred_cnt;
    modport master(output i_fetch_valid, i_fetch_pc, i_ex_valid, i_branch, i_funct3, i_zero_flag,
                   i_ex_pc, i_ex_target, i_ex_pred_taken, i_ex_pred_target,
                   input o_pred_valid, o_pred_taken, o_pred_target, o_pcsrc, o_mispredict, o_redirect_pc,
                   o_branch_cnt, o_mispred_cnt);
    modport slave(input i_fetch_valid, i_fetch_pc, i_ex_valid, i_branch, i_funct3, i_zero_flag,
                  i_ex_pc, i_ex_target, i_ex_pred_taken, i_ex_pred_target,
                  output o_pred_valid, o_pred_taken, o_pred_target, o_pcsrc, o_mispredict, o_redirect_pc,
                  o_branch_cnt, o_mispred_cnt);
`else
    modport master(output i_fetch_valid, i_fetch_pc, i_ex_valid, i_branch, i_funct3, i_zero_flag,
                   i_ex_pc, i_ex_target, i_ex_pred_taken, i_ex_pred_target,
                   input o_pred_valid, o_pred_taken, o_pred_target, o_pcsrc, o_mispredict, o_redirect_pc);
    modport slave(input i_fetch_valid, i_fetch_pc, i_ex_valid, i_branch, i_funct3, i_zero_flag,
                  i_ex_pc, i_ex_target, i_ex_pred_taken, i_ex_pred_target,
                  output o_pred_valid, o_pred_taken, o_pred_target, o_pcsrc, o_mispredict, o_redirect_pc);
`endif
endinterface

// File: rtl/branch_resolver.sv
// branch_resolver: combinational taken decision, pcsrc, mispredict flag and redirect PC
module branch_resolver
    import branch_predictor_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             valid,
    input  logic [1:0]       branch,
    input  logic [2:0]       funct3,
    input  logic             zero_flag,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] target,
    input  logic             pred_taken,
    input  logic [WIDTH-1:0] pred_target,
    output logic [1:0]       pcsrc,
    output logic             mispredict,
    output logic [WIDTH-1:0] redirect_pc,
    output logic             taken
);
    logic b_taken;
    // funct3[0] selects eq/ne polarity; funct3 010/011 are not conditional branches
    always_comb begin
        b_taken     = (funct3[2:1] != 2'b01) && (funct3[0] != zero_flag);
        taken       = valid && (branch == BR_BTYPE ? b_taken : branch[1]);
        pcsrc       = taken ? branch : PCSRC_SEQ;
        mispredict  = valid && branch != BR_NONE && (taken != pred_taken || (taken && target != pred_target));
        redirect_pc = taken ? target : pc + WIDTH'(4);
    end
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit counters, 1-cycle lookup; optional perf counters via BRANCH_PREDICTOR_PERF_EN
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64
) (
    input logic               i_clk,
    input logic               i_rst_n,
    branch_predictor_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int TAG_W = WIDTH - IDX_W - 2;
    logic             tbl_valid [DEPTH];
    logic [TAG_W-1:0] tbl_tag   [DEPTH];
    logic [WIDTH-1:0] tbl_tgt   [DEPTH];
    logic [1:0]       tbl_cnt   [DEPTH];
    logic [IDX_W-1:0] f_idx, u_idx;
    logic [TAG_W-1:0] f_tag, u_tag;
    logic             f_hit, u_hit, upd, ex_taken;
    logic             unused_pc_lsbs;
    assign f_idx          = bus.i_fetch_pc[IDX_W+1:2];
    assign f_tag          = bus.i_fetch_pc[WIDTH-1:IDX_W+2];
    assign u_idx          = bus.i_ex_pc[IDX_W+1:2];
    assign u_tag          = bus.i_ex_pc[WIDTH-1:IDX_W+2];
    assign f_hit          = tbl_valid[f_idx] && tbl_tag[f_idx] == f_tag;
    assign u_hit          = tbl_valid[u_idx] && tbl_tag[u_idx] == u_tag;
    assign upd            = bus.i_ex_valid && bus.i_branch != BR_NONE;
    assign unused_pc_lsbs = ^{bus.i_fetch_pc[1:0], bus.i_ex_pc[1:0]};
    branch_resolver #(.WIDTH(WIDTH)) u_resolver (
        .valid       (bus.i_ex_valid),
        .branch      (bus.i_branch),
        .funct3      (bus.i_funct3),
        .zero_flag   (bus.i_zero_flag),
        .pc          (bus.i_ex_pc),
        .target      (bus.i_ex_target),
        .pred_taken  (bus.i_ex_pred_taken),
        .pred_target (bus.i_ex_pred_target),
        .pcsrc       (bus.o_pcsrc),
        .mispredict  (bus.o_mispredict),
        .redirect_pc (bus.o_redirect_pc),
        .taken       (ex_taken)
    );
    // Table update: train on hit, allocate only on a taken miss
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_valid[i] <= 1'b0;
                tbl_tag[i]   <= '0;
                tbl_tgt[i]   <= '0;
                tbl_cnt[i]   <= SNT;
            end
        end else if (upd && u_hit) begin
            tbl_cnt[u_idx] <= cnt_step(tbl_cnt[u_idx], ex_taken);
            if (ex_taken) tbl_tgt[u_idx] <= bus.i_ex_target;
        end else if (upd && ex_taken) begin
            tbl_valid[u_idx] <= 1'b1;
            tbl_tag[u_idx]   <= u_tag;
            tbl_tgt[u_idx]   <= bus.i_ex_target;
            tbl_cnt[u_idx]   <= bus.i_branch == BR_BTYPE ? WT : ST;
        end
    end
    // Lookup register samples the pre-update table, giving read-before-write on index collisions
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            bus.o_pred_valid  <= 1'b0;
            bus.o_pred_taken  <= 1'b0;
            bus.o_pred_target <= '0;
        end else begin
            bus.o_pred_valid  <= bus.i_fetch_valid;
            bus.o_pred_taken  <= bus.i_fetch_valid && f_hit && tbl_cnt[f_idx][1];
            bus.o_pred_target <= bus.i_fetch_valid && f_hit ? tbl_tgt[f_idx] : '0;
        end
    end
`ifdef BRANCH_PREDICTOR_PERF_EN
    // Free-running wrap-around counts of resolved branches and mispredictions
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            bus.o_branch_cnt  <= '0;
            bus.o_mispred_cnt <= '0;
        end else begin
            bus.o_branch_cnt  <= bus.o_branch_cnt + 32'(upd);
            bus.o_mispred_cnt <= bus.o_mispred_cnt + 32'(bus.o_mispredict);
        end
    end
`endif
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed vectors checked against a table-of-entries model every cycle, plus literal anchors
module tb_branch_predictor;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    branch_predictor_if #(.WIDTH(32)) bus ();
    branch_predictor #(.WIDTH(32), .DEPTH(64)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] tag;
        logic [31:0] tgt;
        int          cnt;
    } ent_t;
    ent_t tbl [int];
    logic        epv = 1'b0;
    logic        ept = 1'b0;
    logic [31:0] eptg = 32'h0;
    logic [31:0] mb = 32'h0;
    logic [31:0] mm = 32'h0;

    typedef struct {
        logic        exv;
        logic [1:0]  br;
        logic [2:0]  f3;
        logic        z;
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        pt;
        logic [31:0] ptg;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic bit m_taken();
        if (!bus.i_ex_valid || bus.i_branch == 2'b00) return 1'b0;
        if (bus.i_branch != 2'b01) return 1'b1;
        case (bus.i_funct3)
            3'd0, 3'd4, 3'd6: return bus.i_zero_flag;
            3'd1, 3'd5, 3'd7: return !bus.i_zero_flag;
            default:          return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] m_pcsrc();
        if (!m_taken()) return 2'b00;
        return bus.i_branch == 2'b01 ? 2'b01 : (bus.i_branch == 2'b10 ? 2'b10 : 2'b11);
    endfunction

    function automatic bit m_mispred();
        if (!bus.i_ex_valid || bus.i_branch == 2'b00) return 1'b0;
        return (m_taken() != bus.i_ex_pred_taken) || (m_taken() && bus.i_ex_target != bus.i_ex_pred_target);
    endfunction

    function automatic logic [31:0] m_redirect();
        return m_taken() ? bus.i_ex_target : bus.i_ex_pc + 32'd4;
    endfunction

    task automatic model_step();
        int fi, ui;
        logic [31:0] ft, ut;
        bit tk;
        if (!rst_n) begin
            tbl.delete();
            epv = 1'b0; ept = 1'b0; eptg = 32'h0; mb = 32'h0; mm = 32'h0;
        end else begin
            fi = int'((bus.i_fetch_pc >> 2) % 64);
            ft = bus.i_fetch_pc >> 8;
            epv = bus.i_fetch_valid; ept = 1'b0; eptg = 32'h0;
            if (epv && tbl.exists(fi) && tbl[fi].tag == ft) begin
                ept = tbl[fi].cnt >= 2;
                eptg = tbl[fi].tgt;
            end
            if (bus.i_ex_valid && bus.i_branch != 2'b00) begin
                mb = mb + 32'd1;
                if (m_mispred()) mm = mm + 32'd1;
                tk = m_taken();
                ui = int'((bus.i_ex_pc >> 2) % 64);
                ut = bus.i_ex_pc >> 8;
                if (tbl.exists(ui) && tbl[ui].tag == ut) begin
                    tbl[ui].cnt = tk ? (tbl[ui].cnt == 3 ? 3 : tbl[ui].cnt + 1) : (tbl[ui].cnt == 0 ? 0 : tbl[ui].cnt - 1);
                    if (tk) tbl[ui].tgt = bus.i_ex_target;
                end else if (tk) begin
                    tbl[ui] = '{ut, bus.i_ex_target, (bus.i_branch == 2'b01) ? 2 : 3};
                end
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        chk("pred_valid", 32'(bus.o_pred_valid), 32'(epv));
        chk("pred_taken", 32'(bus.o_pred_taken), 32'(ept));
        chk("pred_target", bus.o_pred_target, eptg);
        chk("pcsrc", 32'(bus.o_pcsrc), 32'(m_pcsrc()));
        chk("mispredict", 32'(bus.o_mispredict), 32'(m_mispred()));
        chk("redirect_pc", bus.o_redirect_pc, m_redirect());
`ifdef BRANCH_PREDICTOR_PERF_EN
        chk("branch_cnt", bus.o_branch_cnt, mb);
        chk("mispred_cnt", bus.o_mispred_cnt, mm);
`endif
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic fetch(input logic [31:0] pc);
        bus.i_fetch_valid = 1'b1;
        bus.i_fetch_pc = pc;
    endtask

    task automatic no_fetch();
        bus.i_fetch_valid = 1'b0;
        bus.i_fetch_pc = 32'h0;
    endtask

    task automatic set_ex(input logic exv, input logic [1:0] br, input logic [2:0] f3, input logic z,
                          input logic [31:0] pc, input logic [31:0] tgt, input logic pt, input logic [31:0] ptg);
        bus.i_ex_valid = exv;
        bus.i_branch = br;
        bus.i_funct3 = f3;
        bus.i_zero_flag = z;
        bus.i_ex_pc = pc;
        bus.i_ex_target = tgt;
        bus.i_ex_pred_taken = pt;
        bus.i_ex_pred_target = ptg;
    endtask

    task automatic no_ex();
        set_ex(1'b0, 2'b00, 3'd0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask

    vec_t vecs [11];
    logic exp_nt [4];

    initial begin
        vecs = '{
            '{1'b1, 2'b01, 3'd1, 1'b0, 32'h208, 32'h250, 1'b0, 32'h0},
            '{1'b1, 2'b01, 3'd5, 1'b1, 32'h208, 32'h250, 1'b1, 32'h250},
            '{1'b1, 2'b01, 3'd4, 1'b1, 32'h20C, 32'h260, 1'b1, 32'h260},
            '{1'b1, 2'b01, 3'd2, 1'b1, 32'h20C, 32'h260, 1'b0, 32'h0},
            '{1'b1, 2'b01, 3'd3, 1'b0, 32'h20C, 32'h260, 1'b1, 32'h260},
            '{1'b1, 2'b01, 3'd6, 1'b1, 32'h310, 32'h380, 1'b0, 32'h0},
            '{1'b1, 2'b01, 3'd7, 1'b0, 32'h310, 32'h390, 1'b1, 32'h380},
            '{1'b0, 2'b10, 3'd0, 1'b0, 32'h414, 32'h500, 1'b0, 32'h0},
            '{1'b1, 2'b00, 3'd0, 1'b1, 32'h414, 32'h500, 1'b1, 32'h500},
            '{1'b1, 2'b01, 3'd0, 1'b0, 32'hFFFFFFFC, 32'h10, 1'b0, 32'h0},
            '{1'b1, 2'b11, 3'd0, 1'b0, 32'h20C, 32'h700, 1'b1, 32'h700}
        };
        exp_nt = '{1'b1, 1'b0, 1'b0, 1'b0};

        // reset with a lookup and an update presented; both must be discarded
        fetch(32'h100);
        set_ex(1'b1, 2'b10, 3'd0, 1'b0, 32'h100, 32'h999, 1'b0, 32'h0);
        #1;
        chk("rst_comb_pcsrc", 32'(bus.o_pcsrc), 32'd2);
        chk("rst_comb_redirect", bus.o_redirect_pc, 32'h999);
        cycle();
        cycle();
        chk("rst_pred_valid", 32'(bus.o_pred_valid), 32'd0);
        rst_n = 1'b1;
        no_ex();
        fetch(32'h100);
        cycle();
        chk("first_lookup_valid", 32'(bus.o_pred_valid), 32'd1);
        chk("first_lookup_taken", 32'(bus.o_pred_taken), 32'd0);
        chk("first_lookup_target", bus.o_pred_target, 32'h0);

        // beq taken, mispredicted, allocates with counter 10
        no_fetch();
        set_ex(1'b1, 2'b01, 3'd0, 1'b1, 32'h100, 32'h140, 1'b0, 32'h0);
        #1;
        chk("beq_pcsrc", 32'(bus.o_pcsrc), 32'd1);
        chk("beq_mispredict", 32'(bus.o_mispredict), 32'd1);
        chk("beq_redirect", bus.o_redirect_pc, 32'h140);
        cycle();
        no_ex();
        fetch(32'h100);
        cycle();
        chk("beq_lookup_taken", 32'(bus.o_pred_taken), 32'd1);
        chk("beq_lookup_target", bus.o_pred_target, 32'h140);

        // three not-taken resolves with a concurrent lookup: 10 -> 01 -> 00 -> 00
        for (int k = 0; k < 3; k++) begin
            set_ex(1'b1, 2'b01, 3'd0, 1'b0, 32'h100, 32'h140, 1'b1, 32'h140);
            fetch(32'h100);
            #1;
            chk("nt_redirect", bus.o_redirect_pc, 32'h104);
            chk("nt_pcsrc", 32'(bus.o_pcsrc), 32'd0);
            cycle();
            chk("nt_lookup_taken", 32'(bus.o_pred_taken), 32'(exp_nt[k]));
        end
        no_ex();
        cycle();
        chk("nt_saturated_taken", 32'(bus.o_pred_taken), 32'(exp_nt[3]));
        no_fetch();
        set_ex(1'b1, 2'b01, 3'd0, 1'b1, 32'h100, 32'h140, 1'b0, 32'h0);
        cycle();
        no_ex();
        fetch(32'h100);
        cycle();
        chk("sat_then_inc_taken", 32'(bus.o_pred_taken), 32'd0);
        chk("sat_then_inc_target", bus.o_pred_target, 32'h140);

        // JAL aliasing: 0x200 evicts 0x100 at index 0
        no_fetch();
        set_ex(1'b1, 2'b10, 3'd0, 1'b0, 32'h100, 32'h180, 1'b0, 32'h0);
        cycle();
        set_ex(1'b1, 2'b10, 3'd0, 1'b0, 32'h200, 32'h300, 1'b0, 32'h0);
        cycle();
        no_ex();
        fetch(32'h100);
        cycle();
        chk("alias_old_taken", 32'(bus.o_pred_taken), 32'd0);
        chk("alias_old_target", bus.o_pred_target, 32'h0);
        fetch(32'h200);
        cycle();
        chk("alias_new_taken", 32'(bus.o_pred_taken), 32'd1);
        chk("alias_new_target", bus.o_pred_target, 32'h300);

        // same-index lookup and update: lookup sees the old target
        fetch(32'h200);
        set_ex(1'b1, 2'b11, 3'd0, 1'b0, 32'h200, 32'h600, 1'b1, 32'h300);
        #1;
        chk("rbw_mispredict", 32'(bus.o_mispredict), 32'd1);
        chk("rbw_pcsrc", 32'(bus.o_pcsrc), 32'd3);
        cycle();
        chk("rbw_old_target", bus.o_pred_target, 32'h300);
        no_ex();
        cycle();
        chk("rbw_new_target", bus.o_pred_target, 32'h600);

        // wrap of pc+4
        set_ex(1'b1, 2'b01, 3'd0, 1'b0, 32'hFFFFFFFC, 32'h10, 1'b0, 32'h0);
        #1;
        chk("wrap_redirect", bus.o_redirect_pc, 32'h0);

        // assorted funct3 / kind vectors, each with a lookup of the same PC
        foreach (vecs[i]) begin
            set_ex(vecs[i].exv, vecs[i].br, vecs[i].f3, vecs[i].z, vecs[i].pc, vecs[i].tgt, vecs[i].pt, vecs[i].ptg);
            fetch(vecs[i].pc);
            cycle();
        end
        no_ex();
        cycle();

        // mid-run reset clears table, prediction register and counters
        rst_n = 1'b0;
        fetch(32'h200);
        set_ex(1'b1, 2'b10, 3'd0, 1'b0, 32'h20C, 32'h900, 1'b0, 32'h0);
        cycle();
        rst_n = 1'b1;
        no_ex();
        chk("rst2_pred_valid", 32'(bus.o_pred_valid), 32'd0);
        chk("rst2_pred_target", bus.o_pred_target, 32'h0);
`ifdef BRANCH_PREDICTOR_PERF_EN
        chk("rst2_branch_cnt", bus.o_branch_cnt, 32'd0);
        chk("rst2_mispred_cnt", bus.o_mispred_cnt, 32'd0);
`endif
        cycle();
        fetch(32'h20C);
        cycle();
        chk("rst2_lookup_taken", 32'(bus.o_pred_taken), 32'd0);
        chk("rst2_lookup_valid", 32'(bus.o_pred_valid), 32'd1);
        no_fetch();
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter WIDTH, default 32, is the PC/target width in bits.
REQ-002 Parameter DEPTH, default 64, is the table entry count; power of two, 4..1024; IDX_W = log2(DEPTH).
REQ-003 Port i_clk, input, 1: sole clock; all state updates on rising edge.
REQ-004 Port i_rst_n, input, 1: synchronous, active-low reset.
REQ-005 Port i_fetch_valid / i_fetch_pc, input, 1 / WIDTH: fetch-stage lookup request.
REQ-006 Port o_pred_valid / o_pred_taken / o_pred_target, output, 1 / 1 / WIDTH: registered prediction for the previous cycle's lookup.
REQ-007 Port i_ex_valid / i_branch / i_funct3 / i_zero_flag, input, 1 / 2 / 3 / 1: execute-stage resolution inputs. i_branch encoding: 01 = B-type, 10 = JAL, 11 = JALR, 00 = none.
REQ-008 Port i_ex_pc / i_ex_target / i_ex_pred_taken / i_ex_pred_target, input, WIDTH / WIDTH / 1 / WIDTH: resolving instruction PC, computed target, and the prediction it carried.
REQ-009 Port o_pcsrc / o_mispredict / o_redirect_pc, output, 2 / 1 / WIDTH: combinational resolution result, flush request and correct next PC.

Function
REQ-010 Actual taken SHALL be decided as follows.
- B-type: funct3 000/100/110 taken when i_zero_flag=1; 001/101/111 taken when i_zero_flag=0; any other funct3 is not taken.
- i_branch 10 or 11: always taken.
REQ-011 o_pcsrc SHALL be 00 when not taken, 01 for a taken B-type, 10 for JAL and 11 for JALR; it SHALL be 00 when i_ex_valid=0.
REQ-012 o_mispredict SHALL be 1 only when i_ex_valid=1, i_branch!=00, and either (actual taken != i_ex_pred_taken) or (taken and i_ex_target != i_ex_pred_target).
REQ-013 o_redirect_pc SHALL be i_ex_target when taken, otherwise i_ex_pc+4 (mod 2^WIDTH).
REQ-014 Entry layout: valid, tag = pc[WIDTH-1:IDX_W+2], target (WIDTH bits), and a 2-bit saturating counter. Index = pc[IDX_W+1:2].
REQ-015 Lookup latency SHALL be 1 cycle.
- o_pred_valid(t+1) = i_fetch_valid(t).
- o_pred_taken = hit & counter[1], where hit = valid & tag match.
- o_pred_target = entry target on hit, else 0.
- When i_fetch_valid=0, o_pred_taken=0 and o_pred_target=0.
REQ-016 An update SHALL occur when i_ex_valid=1 and i_branch!=00, and take effect at the clock edge.
- Hit, taken: counter increments, saturating at 11; target is overwritten.
- Hit, not taken: counter decrements, saturating at 00.
- Miss, taken: allocate the entry (overwriting any occupant) with valid=1, the new tag and target; counter=10 for B-type, 11 for JAL/JALR.
- Miss, not taken: no change.
REQ-017 On a simultaneous lookup and update to the same index, the lookup SHALL return the pre-update entry (read-before-write).
REQ-018 i_ex_valid=0 or i_branch=00 SHALL leave all state unchanged.

Reset
REQ-019 While i_rst_n=0 at a clock edge, the following SHALL be cleared in that single cycle:
- all valid bits and counters (to 00) and all targets;
- o_pred_valid, o_pred_taken and o_pred_target.
REQ-020 A lookup or update presented in a reset cycle SHALL be discarded; normal operation starts on the first edge with i_rst_n=1.
REQ-021 Combinational outputs (o_pcsrc, o_mispredict, o_redirect_pc) SHALL follow their inputs regardless of reset.

Configuration
REQ-022 When macro BRANCH_PREDICTOR_PERF_EN is defined, the following SHALL be present:
- 32-bit output o_branch_cnt: counts updates.
- 32-bit output o_mispred_cnt: counts o_mispredict=1 cycles.
- Both wrap at 2^32 and are cleared by reset.
REQ-023 When BRANCH_PREDICTOR_PERF_EN is undefined, those ports and counters SHALL NOT exist; all other behaviour is identical.

Structure
REQ-024 A shared package SHALL hold:
- branch-kind constants (NONE/BTYPE/JAL/JALR);
- pcsrc constants (00/01/10/11);
- counter constants SNT=00, WNT=01, WT=10, ST=11.
REQ-025 Resolution logic (REQ-010..013) SHALL be a combinational sub-module, branch_resolver; the tables, lookup register and counters live in branch_predictor.

Verification
REQ-026 Reset, then lookup of PC 0x100 -> next cycle o_pred_valid=1, o_pred_taken=0, o_pred_target=0.
REQ-027 Resolve B-type beq at 0x100, zero_flag=1, target 0x140, pred_taken=0 -> o_pcsrc=01, o_mispredict=1, o_redirect_pc=0x140; a following lookup of 0x100 -> taken=1, target=0x140.
REQ-028 Three not-taken resolves of that 0x100 beq -> counter goes 10, 01, 00, 00 (saturates); lookup -> taken=0; o_redirect_pc=0x104 each time.
REQ-029 With DEPTH=64, JAL at 0x100 then JAL at 0x200 (same index, different tag), target 0x300 -> lookup 0x100 misses (taken=0); lookup 0x200 -> taken=1, target 0x300.
REQ-030 Lookup and taken update of the same index in one cycle -> the lookup returns the old entry; the next lookup returns the new one; with BRANCH_PREDICTOR_PERF_EN, o_branch_cnt and o_mispred_cnt match the scoreboard and clear on reset.
